alu_control_md: RTL and testbench

- EX-stage ALU control for the RV32 core, generalised to XLEN and extended with the RV32M multiply/divide path.
- Combinationally decodes ALUop/funct3/funct7 into ALUControl/BranchOp/SLTc using the existing encodings.
- Owns an iterative shift-add multiplier / restoring divider FSM with a stall/done handshake to the hazard unit.

---
 rtl/alu_control_md_if.sv | 30 +++
 rtl/alu_control_md.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_control_md.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_control_md_if.sv
// EX-stage ALU control bus: instruction fields and operands in, decode and
// multiply/divide results out. The EX stage drives the master side and
// alu_control_md implements the slave side.
interface alu_control_md_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic            flush_i;
    logic [1:0]      ALUop;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [2:0]      ALUControl;
    logic [1:0]      BranchOp;
    logic            SLTc;
    logic            md_stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    modport master (
        output valid_i, flush_i, ALUop, funct3, funct7, op_a, op_b,
        input  ALUControl, BranchOp, SLTc, md_stall, md_done, md_result
    );

    modport slave (
        input  valid_i, flush_i, ALUop, funct3, funct7, op_a, op_b,
        output ALUControl, BranchOp, SLTc, md_stall, md_done, md_result
    );
endinterface

// File: rtl/alu_control_md.sv
// EX-stage ALU control with an iterative RV32M-style multiply/divide unit.
// The ALU decode is purely combinational. M-ops run on a shift-add multiplier
// or restoring divider, one bit per cycle, on operand magnitudes with a final
// sign correction. XLEN must be >= 8 and even.
// Optional feature macro: ALU_MD_EARLY_OUT_EN (zero-operand early out).
module alu_control_md #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    alu_control_md_if.slave bus
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SRL = 3'b011;
    localparam logic [2:0] ALU_SRA = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] BR_EQ  = 2'b00;
    localparam logic [1:0] BR_NE  = 2'b01;
    localparam logic [1:0] BR_LT  = 2'b10;
    localparam logic [1:0] BR_LTU = 2'b11;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;        // {hi, lo}: product or {remainder, quotient}
    logic [XLEN-1:0]     opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [2:0]          f3_q, f3_d;
    logic                neg_res_q, neg_res_d; // product / quotient is negative
    logic                neg_rem_q, neg_rem_d; // remainder follows the dividend sign
    logic                byp_q, byp_d;         // result precomputed at acceptance
    logic [XLEN-1:0]     md_result_q, md_result_d;

    logic [2:0]          alu_ctrl;
    logic [1:0]          br_op;
    logic                slt_c;
    logic                is_md;

    // Acceptance-time operand preparation.
    logic                mul_op, a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf, early_zero, byp;
    logic [XLEN-1:0]     spec_res;

    // One iteration step and final sign correction.
    logic [XLEN:0]       mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, step_acc, prod;
    logic [XLEN-1:0]     quo, rem, fin_result;

    assign is_md = (bus.ALUop == 2'b10) && (bus.funct7 == 7'b0000001);

    // Combinational ALU decode from ALUop/funct3/funct7.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        alu_ctrl = ALU_ADD;
        br_op    = BR_EQ;
        slt_c    = 1'b0;
        if (!is_md) begin
            case (bus.ALUop)
                2'b01: begin
                    case (bus.funct3)
                        3'b000:         begin alu_ctrl = ALU_SUB; br_op = BR_EQ;  end
                        3'b001:         begin alu_ctrl = ALU_SUB; br_op = BR_NE;  end
                        3'b100, 3'b101: begin alu_ctrl = ALU_SUB; br_op = BR_LT;  end
                        3'b110, 3'b111: begin alu_ctrl = ALU_SUB; br_op = BR_LTU; end
                        default: ;
                    endcase
                end
                2'b10, 2'b11: begin
                    case (bus.funct3)
                        3'b000: alu_ctrl = (bus.ALUop == 2'b10 && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001: alu_ctrl = ALU_SLL;
                        3'b010: begin alu_ctrl = ALU_SUB; br_op = BR_LT;  slt_c = 1'b1; end
                        3'b011: begin alu_ctrl = ALU_SUB; br_op = BR_LTU; slt_c = 1'b1; end
                        3'b100: alu_ctrl = ALU_XOR;
                        3'b101: alu_ctrl = bus.funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110: alu_ctrl = ALU_OR;
                        default: alu_ctrl = ALU_AND;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUControl = alu_ctrl;
    assign bus.BranchOp   = br_op;
    assign bus.SLTc       = slt_c;

    // Signedness per op: MULH both, MULHSU rs1 only, MUL/MULHU none; DIV/REM both.
    assign mul_op   = ~bus.funct3[2];
    assign a_signed = mul_op ? (bus.funct3 == 3'b001 || bus.funct3 == 3'b010) : ~bus.funct3[0];
    assign b_signed = mul_op ? (bus.funct3 == 3'b001) : ~bus.funct3[0];
    assign neg_a    = a_signed & bus.op_a[XLEN-1];
    assign neg_b    = b_signed & bus.op_b[XLEN-1];
    assign a_mag    = neg_a ? -bus.op_a : bus.op_a;
    assign b_mag    = neg_b ? -bus.op_b : bus.op_b;
    assign div_zero = ~mul_op & (bus.op_b == '0);
    assign div_ovf  = ~mul_op & ~bus.funct3[0] & (bus.op_a == MOST_NEG) & (bus.op_b == '1);
`ifdef ALU_MD_EARLY_OUT_EN
    assign early_zero = mul_op ? (bus.op_a == '0 || bus.op_b == '0)
                               : (bus.op_a == '0 && bus.op_b != '0);
`else
    assign early_zero = 1'b0;
`endif
    assign byp = div_zero | div_ovf | early_zero;

    // Precomputed result for the cases that skip iteration; funct3[1] selects REM.
    always_comb begin
        spec_res = '0;
        if (div_zero)
            spec_res = bus.funct3[1] ? bus.op_a : '1;
        else if (div_ovf)
            spec_res = bus.funct3[1] ? '0 : bus.op_a;
    end

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign step_acc  = (state_q == S_MUL) ? mul_next : div_next;
    assign prod      = neg_res_q ? -step_acc : step_acc;
    assign quo       = neg_res_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    assign rem       = neg_rem_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

    // Final result selection from the last iteration step.
    always_comb begin
        if (byp_q)
            fin_result = acc_q[XLEN-1:0];
        else if (!f3_q[2])
            fin_result = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            fin_result = f3_q[1] ? rem : quo;
    end

    // Next-state and datapath update; flush wins over everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        f3_d        = f3_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        byp_d       = byp_q;
        md_result_d = md_result_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.valid_i && is_md) begin
                        state_d   = mul_op ? S_MUL : S_DIV;
                        f3_d      = bus.funct3;
                        neg_res_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        byp_d     = byp;
                        // Special cases make a single pass so md_done lands at cycle 2.
                        if (byp) begin
                            cnt_d = '0;
                            acc_d = {{XLEN{1'b0}}, spec_res};
                        end else begin
                            cnt_d  = CNT_W'(XLEN - 1);
                            opnd_d = mul_op ? a_mag : b_mag;
                            acc_d  = {{XLEN{1'b0}}, mul_op ? b_mag : a_mag};
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d     = S_DONE;
                        cnt_d       = '0;
                        md_result_d = fin_result;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            f3_q        <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            byp_q       <= 1'b0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            f3_q        <= f3_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            byp_q       <= byp_d;
            md_result_q <= md_result_d;
        end
    end

    // Handshake outputs to the hazard unit.
    always_comb begin
        bus.md_stall = bus.valid_i & is_md & (state_q != S_DONE);
        bus.md_done  = (state_q == S_DONE);
    end

    assign bus.md_result = md_result_q;
endmodule

// File: tb/tb_alu_control_md.sv
// Self-checking bench for alu_control_md (XLEN=32): directed test-plan vectors
// plus randomized decode and M-op stimulus against a behavioural model.
module tb_alu_control_md;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] last_result;

    alu_control_md_if #(.XLEN(XLEN)) bus ();

    alu_control_md #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Decode model: returns {ALUControl, BranchOp, SLTc}.
    function automatic logic [5:0] dec_ref(input logic [1:0] aluop, input logic [2:0] f3,
                                           input logic [6:0] f7);
        logic [23:0] tbl;
        logic [2:0]  alu;
        logic [1:0]  br;
        logic        slt;
        tbl = {3'b111, 3'b110, 3'b011, 3'b101, 3'b001, 3'b001, 3'b010, 3'b000};
        alu = 3'b000; br = 2'b00; slt = 1'b0;
        if (aluop == 2'b01) begin
            if (f3 != 3'b010 && f3 != 3'b011) begin
                alu = 3'b001;
                br  = (f3 == 3'b000) ? 2'b00 : (f3 == 3'b001) ? 2'b01 : (f3[1] ? 2'b11 : 2'b10);
            end
        end else if (aluop[1] && !(aluop == 2'b10 && f7 == 7'h01)) begin
            alu = tbl[f3*3 +: 3];
            if (f3 == 3'b000 && aluop == 2'b10 && f7[5]) alu = 3'b001;
            if (f3 == 3'b101 && f7[5]) alu = 3'b100;
            if (f3 == 3'b010) br = 2'b10;
            if (f3 == 3'b011) br = 2'b11;
            slt = (f3 == 3'b010 || f3 == 3'b011);
        end
        return {alu, br, slt};
    endfunction

    // M-op result model using native 64-bit and signed integer arithmetic.
    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a; sb = b;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycle on which md_done is expected, counting the accept cycle as 0.
    function automatic int lat_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 2;
`ifdef ALU_MD_EARLY_OUT_EN
        if (!f3[2] && (a == 0 || b == 0)) return 2;
        if (f3[2] && a == 0 && b != 0) return 2;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_NEG;
            4: return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    // Apply one decode vector (valid_i low) and compare the three decode outputs.
    task automatic check_dec(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                             input string tag);
        bus.valid_i = 1'b0;
        bus.ALUop   = aluop;
        bus.funct3  = f3;
        bus.funct7  = f7;
        @(negedge clk);
        check(tag, {bus.ALUControl, bus.BranchOp, bus.SLTc}, dec_ref(aluop, f3, f7));
        @(posedge clk); #1;
    endtask

    // Issue one M-op held until md_done; operands are scrambled after acceptance.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int cyc, stalls, exp_c;
        logic [31:0] exp_r;
        bit got;
        exp_r = md_ref(f3, a, b);
        exp_c = lat_ref(f3, a, b);
        bus.valid_i = 1'b1; bus.flush_i = 1'b0;
        bus.ALUop = 2'b10; bus.funct7 = 7'h01; bus.funct3 = f3;
        bus.op_a = a; bus.op_b = b;
        cyc = 0; stalls = 0; got = 1'b0;
        while (cyc <= 200) begin
            @(negedge clk);
            if (cyc == 0) check({tag, "_hold"}, bus.md_result, last_result);
            if (bus.md_done) begin got = 1'b1; break; end
            if (bus.md_stall) stalls++;
            @(posedge clk); #1;
            bus.op_a = $urandom; bus.op_b = $urandom; bus.funct3 = 3'($urandom);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_c);
        check({tag, "_stall_cycles"}, stalls, exp_c);
        check({tag, "_stall_at_done"}, bus.md_stall, 1'b0);
        check({tag, "_result"}, bus.md_result, exp_r);
        if (got) last_result = exp_r;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.flush_i = 1'b0;
        bus.ALUop = 2'b00; bus.funct3 = 3'b000; bus.funct7 = 7'h00;
        bus.op_a = '0; bus.op_b = '0;
        last_result = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_md_done", bus.md_done, 1'b0);
        check("reset_md_result", bus.md_result, 32'h0);
        check("reset_md_stall", bus.md_stall, 1'b0);
        @(posedge clk); #1;

        // Directed decode vectors.
        check_dec(2'b10, 3'b000, 7'h20, "dec_r_sub");
        check_dec(2'b10, 3'b000, 7'h00, "dec_r_add");
        check_dec(2'b10, 3'b100, 7'h00, "dec_r_xor");
        check_dec(2'b10, 3'b111, 7'h00, "dec_r_and");
        check_dec(2'b11, 3'b010, 7'h00, "dec_i_slt");
        check_dec(2'b11, 3'b011, 7'h00, "dec_i_sltu");
        check_dec(2'b11, 3'b000, 7'h20, "dec_i_addi_f7");
        check_dec(2'b10, 3'b101, 7'h20, "dec_r_sra");
        check_dec(2'b01, 3'b001, 7'h00, "dec_br_ne");
        check_dec(2'b00, 3'b111, 7'h7f, "dec_add");
        check_dec(2'b10, 3'b010, 7'h01, "dec_md_default");

        // Randomized decode.
        for (int i = 0; i < 60; i++) begin
            logic [6:0] f7;
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            check_dec(2'($urandom), 3'($urandom), f7, "dec_rand");
        end

        // Directed M-ops.
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        run_md(3'd3, 32'd7, 32'hFFFF_FFFD, "mulhu_7_m3");
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_md(3'd5, 32'd1234, 32'd0, "divu_by0");
        run_md(3'd6, 32'd1234, 32'd0, "rem_by0");
        run_md(3'd4, MIN_NEG, 32'hFFFF_FFFF, "div_ovf");
        run_md(3'd6, MIN_NEG, 32'hFFFF_FFFF, "rem_ovf");
        run_md(3'd0, 32'h1234, 32'd0, "mul_b0");
        run_md(3'd5, 32'd0, 32'd9, "divu_a0");

        // Flush at cycle 10 of a DIV, then a MUL accepted right after.
        bus.valid_i = 1'b1; bus.ALUop = 2'b10; bus.funct7 = 7'h01; bus.funct3 = 3'd4;
        bus.op_a = 32'd1000; bus.op_b = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("flush_no_done_c10", bus.md_done, 1'b0);
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.valid_i = 1'b0;
        @(negedge clk);
        check("flush_stall_low", bus.md_stall, 1'b0);
        check("flush_no_done", bus.md_done, 1'b0);
        check("flush_result_kept", bus.md_result, last_result);
        @(posedge clk); #1;
        run_md(3'd0, 32'd3, 32'd5, "mul_after_flush");

        // Reset at cycle 5 of a MUL.
        bus.valid_i = 1'b1; bus.ALUop = 2'b10; bus.funct7 = 7'h01; bus.funct3 = 3'd0;
        bus.op_a = 32'd11; bus.op_b = 32'd13;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; bus.valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_done", bus.md_done, 1'b0);
        check("rst_mid_result", bus.md_result, 32'h0);
        check("rst_mid_stall", bus.md_stall, 1'b0);
        last_result = '0;
        @(posedge clk); #1;
        run_md(3'd1, 32'hFFFF_FF00, 32'd300, "mulh_after_rst");

        // Randomized M-ops, issued back to back.
        for (int i = 0; i < 40; i++)
            run_md(3'($urandom), pick_operand(), pick_operand(), "md_rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
